// File: rtl/rgb_led_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_led_arbiter
//  Description : Fixed-priority arbiter that gives one of four requesters
//                ownership of a single RGB LED. An owner keeps the LED for
//                at least MIN_HOLD cycles. The LED is then forced dark for
//                GAP_CYCLES cycles before a different owner, or the same
//                owner again, is granted.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MIN_HOLD   : minimum cycles a granted requester owns the LED (>= 1)
//    GAP_CYCLES : dark cycles between two ownerships (>= 1)
//  Ports
//    clk        : system clock
//    n_rst      : synchronous active-low reset
//    req[3:0]   : level requests, bit 3 has the highest priority
//    rgb_in     : 4 x 24-bit colours, requester i at [24*i+23:24*i], R in MSBs
//    blink_in   : per-requester blink enable
//    gnt        : registered one-hot grant, zero when nobody owns the LED
//    rgb        : registered colour to the PWM driver, zero unless showing
//    blink_en   : registered blink enable to the PWM driver
//    busy       : registered, high while showing or in the dark gap
// ============================================================================
module rgb_led_arbiter #(
    parameter logic [31:0] MIN_HOLD   = 32'd27_000_000,
    parameter logic [31:0] GAP_CYCLES = 32'd2_700_000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [3:0]  req,
    input  logic [95:0] rgb_in,
    input  logic [3:0]  blink_in,
    output logic [3:0]  gnt,
    output logic [23:0] rgb,
    output logic        blink_en,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_owner;
    logic [1:0]  w_owner_nxt;
    logic [31:0] r_hold_cnt;
    logic [31:0] w_hold_nxt;
    logic [31:0] r_gap_cnt;
    logic [31:0] w_gap_nxt;

    logic        w_any_req;
    logic [1:0]  w_top_idx;
    logic        w_higher_req;
    logic        w_show_nxt;

    logic [23:0] w_rgb_slice [4];

    // Unpack the flat colour bus into one word per requester.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign w_rgb_slice[gi] = rgb_in[24*gi +: 24];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Fixed-priority encoder: highest asserted request index.
    // ------------------------------------------------------------------
    assign w_any_req = |req;

    always_comb begin
        w_top_idx = 2'd0;
        if (req[3]) begin
            w_top_idx = 2'd3;
        end else if (req[2]) begin
            w_top_idx = 2'd2;
        end else if (req[1]) begin
            w_top_idx = 2'd1;
        end else begin
            w_top_idx = 2'd0;
        end
    end

    // Any request with strictly higher priority than the current owner.
    always_comb begin
        w_higher_req = 1'b0;
        case (r_owner)
            2'd0:    w_higher_req = |req[3:1];
            2'd1:    w_higher_req = |req[3:2];
            2'd2:    w_higher_req = req[3];
            default: w_higher_req = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold_cnt;
        w_gap_nxt   = r_gap_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_SHOW;
                    w_owner_nxt = w_top_idx;
                    w_hold_nxt  = MIN_HOLD - 32'd1;
                end
            end

            ST_SHOW: begin
                if (r_hold_cnt != 32'd0) begin
                    // Minimum hold still running: no release, no preemption.
                    w_hold_nxt = r_hold_cnt - 32'd1;
                end else if (!req[r_owner] || w_higher_req) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GAP_CYCLES - 32'd1;
                end
                // Otherwise the owner keeps the LED with hold_cnt parked at 0.
            end

            ST_GAP: begin
                if (r_gap_cnt != 32'd0) begin
                    w_gap_nxt = r_gap_cnt - 32'd1;
                end else if (w_any_req) begin
                    // Previous owner may win again if it is still on top.
                    w_state_nxt = ST_SHOW;
                    w_owner_nxt = w_top_idx;
                    w_hold_nxt  = MIN_HOLD - 32'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 32'd0;
                w_gap_nxt   = 32'd0;
            end
        endcase
    end

    assign w_show_nxt = (w_state_nxt == ST_SHOW);

    // ------------------------------------------------------------------
    // State and output registers. Outputs are computed from the next
    // state so grant and colour appear one cycle after the request, and
    // the colour is a one-cycle-delayed copy of the owner's input.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= 2'd0;
            r_hold_cnt <= 32'd0;
            r_gap_cnt  <= 32'd0;
            gnt        <= 4'd0;
            rgb        <= 24'd0;
            blink_en   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
            gnt        <= w_show_nxt ? (4'b0001 << w_owner_nxt) : 4'd0;
            rgb        <= w_show_nxt ? w_rgb_slice[w_owner_nxt] : 24'd0;
            blink_en   <= w_show_nxt ? blink_in[w_owner_nxt] : 1'b0;
            busy       <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_led_arbiter
//  Description : Scoreboard bench for rgb_led_arbiter with MIN_HOLD=4 and
//                GAP_CYCLES=2. A reference model predicts the registered
//                outputs for every clock edge; a monitor compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_led_arbiter;

    localparam int C_MIN_HOLD = 4;
    localparam int C_GAP      = 2;

    logic        clk;
    logic        n_rst;
    logic [3:0]  req;
    logic [95:0] rgb_in;
    logic [3:0]  blink_in;
    logic [3:0]  gnt;
    logic [23:0] rgb;
    logic        blink_en;
    logic        busy;

    rgb_led_arbiter #(
        .MIN_HOLD   (32'd4),
        .GAP_CYCLES (32'd2)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .req      (req),
        .rgb_in   (rgb_in),
        .blink_in (blink_in),
        .gnt      (gnt),
        .rgb      (rgb),
        .blink_en (blink_en),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [23:0] rgb;
        logic        blink;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   stim_done = 1'b0;

    // Reference model: mode 0 = dark/idle, 1 = owner showing, 2 = dark gap.
    int m_mode   = 0;
    int m_owner  = 0;
    int m_shown  = 0;   // cycles the owner has been on the LED so far
    int m_gapped = 0;   // cycles of the gap elapsed so far

    function automatic int top_req(input logic [3:0] r);
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic grant_new(input logic [3:0] r);
        m_mode  = 1;
        m_owner = top_req(r);
        m_shown = 1;
    endtask

    // Advance the model by one clock edge and queue the outputs it predicts.
    task automatic model_edge();
        exp_t e;
        if (!n_rst) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (req != 4'd0) grant_new(req);
                1: begin
                    if (m_shown < C_MIN_HOLD) begin
                        m_shown++;
                    end else if (!req[m_owner] || top_req(req) > m_owner) begin
                        m_mode   = 2;
                        m_gapped = 1;
                    end
                end
                default: begin
                    if (m_gapped < C_GAP) m_gapped++;
                    else if (req != 4'd0) grant_new(req);
                    else m_mode = 0;
                end
            endcase
        end
        e.gnt   = (m_mode == 1) ? 4'(1 << m_owner) : 4'd0;
        e.rgb   = (m_mode == 1) ? rgb_in[24*m_owner +: 24] : 24'd0;
        e.blink = (m_mode == 1) ? blink_in[m_owner] : 1'b0;
        e.busy  = (m_mode != 0);
        exp_q.push_back(e);
    endtask

    // Apply one cycle of stimulus (inputs already set by caller) then wait.
    task automatic step(input logic [3:0] r, input logic nr);
        req   = r;
        n_rst = nr;
        model_edge();
        @(negedge clk);
    endtask

    task automatic steps(input logic [3:0] r, input int n);
        for (int k = 0; k < n; k++) step(r, 1'b1);
    endtask

    // Monitor: one expected vector per rising edge, compared 1 time unit later.
    initial begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (gnt !== e.gnt || rgb !== e.rgb || blink_en !== e.blink || busy !== e.busy) begin
                    n_err++;
                    $display("FAIL outputs cycle %0d: got gnt=%b rgb=%h blink_en=%b busy=%b, expected gnt=%b rgb=%h blink_en=%b busy=%b",
                             cyc, gnt, rgb, blink_en, busy, e.gnt, e.rgb, e.blink, e.busy);
                end
                n_vec++;
                if ($countones(gnt) > 1 || (rgb !== 24'd0 && gnt === 4'd0)) begin
                    n_err++;
                    $display("FAIL onehot cycle %0d: got gnt=%b rgb=%h, required one-hot/zero grant and dark LED without owner",
                             cyc, gnt, rgb);
                end
            end
        end
    end

    initial begin : stimulus
        req      = 4'd0;
        n_rst    = 1'b0;
        rgb_in   = '0;
        blink_in = 4'd0;

        // Reset
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        steps(4'd0, 2);

        // Single short request from the lowest requester
        rgb_in[23:0] = 24'hFF0000;
        rgb_in[95:72] = 24'h0000FF;
        rgb_in[47:24] = 24'h00FF00;
        rgb_in[71:48] = 24'h123456;
        steps(4'b0001, 1);
        steps(4'b0000, 8);

        // Preemption after minimum hold
        steps(4'b0001, 2);
        steps(4'b1001, 8);
        steps(4'b0000, 6);

        // Lower priority waits while higher holds
        steps(4'b1010, 12);
        steps(4'b0010, 8);
        steps(4'b0000, 8);

        // Owner 2 with changing colour and toggling blink
        for (int k = 0; k < 10; k++) begin
            blink_in[2]   = k[0];
            rgb_in[71:48] = 24'h100000 + 24'(k * 24'h010203);
            step(4'b0100, 1'b1);
        end
        blink_in = 4'd0;
        steps(4'b0000, 8);

        // Reset in the middle of a show, request still high
        steps(4'b0001, 2);
        step(4'b0001, 1'b0);
        steps(4'b0001, 8);
        steps(4'b0000, 8);

        // All requests at once
        steps(4'b1111, 6);
        steps(4'b0000, 8);

        // Randomised run
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 3) == 0) rgb_in[24*s +: 24] = 24'($urandom);
            end
            blink_in = 4'($urandom);
            step(req, ($urandom_range(0, 199) != 0));
        end
        steps(4'b0000, 10);

        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked vectors, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
